// File: rtl/traffic_light_ctrl.sv
// Two-road intersection light controller.
// Phases are timed in prescaled ticks. Includes all-red clearance between
// greens, a latched pedestrian request served by a walk phase, and a
// flashing fail-safe mode. All outputs are registered and decode the state
// being entered on the same edge as the state register.
module traffic_light_ctrl #(
   parameter int PRESCALE        = 10,
   parameter int CNT_W           = 8,
   parameter int GREEN_TICKS     = 20,
   parameter int MIN_GREEN_TICKS = 5,
   parameter int YELLOW_TICKS    = 4,
   parameter int ALL_RED_TICKS   = 2,
   parameter int WALK_TICKS      = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic [1:0] light_a,
   output logic [1:0] light_b,
   output logic       walk,
   output logic       ped_pending
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST      = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_LAST     = CNT_W'(MIN_GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TICKS - 1);
   localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_TICKS - 1);

   localparam logic [1:0] L_RED    = 2'd0;
   localparam logic [1:0] L_GREEN  = 2'd1;
   localparam logic [1:0] L_YELLOW = 2'd2;
   localparam logic [1:0] L_OFF    = 2'd3;

   typedef enum logic [2:0] {
      A_GREEN, A_YELLOW, ALL_RED_A, B_GREEN, B_YELLOW, ALL_RED_B, PED_WALK, FLASH
   } state_t;

   state_t            state_reg, state_next;
   logic [PS_W-1:0]   presc_reg;
   logic [CNT_W-1:0]  phase_cnt_reg;
   logic              next_is_b_reg, next_is_b_next;
   logic              flash_phase_reg, flash_phase_next;
   logic              tick;
   logic              green_exit;
   logic              enter_walk;

   // Destination at the end of an all-red clearance: flash first, then a
   // pending pedestrian, otherwise the green of the road whose turn it is.
   function automatic state_t clear_exit(input logic fl, input logic pp, input logic to_b);
      if (fl)
         return FLASH;
      else if (pp)
         return PED_WALK;
      else
         return to_b ? B_GREEN : A_GREEN;
   endfunction

   assign tick = (presc_reg == PS_LAST);

   // Green ends at full length, or early once the minimum has elapsed if
   // someone is waiting to cross or fail-safe flashing is requested.
   assign green_exit = (phase_cnt_reg == GREEN_LAST) ||
                       ((ped_pending || flash_en) && (phase_cnt_reg >= MIN_LAST));

   assign enter_walk = (state_next == PED_WALK) && (state_reg != PED_WALK);

   // Free-running tick prescaler.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         presc_reg <= '0;
      else if (tick)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + 1'b1;
   end

   // Next-state, road-turn and flash-phase decisions, evaluated only on ticks.
   always_comb begin
      state_next       = state_reg;
      next_is_b_next   = next_is_b_reg;
      flash_phase_next = flash_phase_reg;
      if (tick) begin
         case (state_reg)
            A_GREEN:   if (green_exit) state_next = A_YELLOW;
            A_YELLOW:  if (phase_cnt_reg == YELLOW_LAST) state_next = ALL_RED_A;
            ALL_RED_A: if (phase_cnt_reg == ALL_RED_LAST) begin
                          next_is_b_next = 1'b1;
                          state_next     = clear_exit(flash_en, ped_pending, 1'b1);
                       end
            B_GREEN:   if (green_exit) state_next = B_YELLOW;
            B_YELLOW:  if (phase_cnt_reg == YELLOW_LAST) state_next = ALL_RED_B;
            ALL_RED_B: if (phase_cnt_reg == ALL_RED_LAST) begin
                          next_is_b_next = 1'b0;
                          state_next     = clear_exit(flash_en, ped_pending, 1'b0);
                       end
            PED_WALK:  if (phase_cnt_reg == WALK_LAST)
                          state_next = next_is_b_reg ? B_GREEN : A_GREEN;
            FLASH:     begin
                          flash_phase_next = ~flash_phase_reg;
                          if (!flash_en) state_next = ALL_RED_B;
                       end
            default:   state_next = state_reg;
         endcase
         // Flashing always starts on the lit (yellow) half.
         if ((state_next == FLASH) && (state_reg != FLASH))
            flash_phase_next = 1'b0;
      end
   end

   // State, phase counter, pedestrian latch and registered lamp outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ALL_RED_B;
         phase_cnt_reg   <= '0;
         next_is_b_reg   <= 1'b0;
         flash_phase_reg <= 1'b0;
         ped_pending     <= 1'b0;
         light_a         <= L_RED;
         light_b         <= L_RED;
         walk            <= 1'b0;
      end else begin
         state_reg       <= state_next;
         next_is_b_reg   <= next_is_b_next;
         flash_phase_reg <= flash_phase_next;
         if (tick)
            phase_cnt_reg <= (state_next != state_reg) ? '0 : phase_cnt_reg + 1'b1;
         // A new request on the walk-entry edge survives the clear.
         ped_pending <= ped_req | (ped_pending & ~enter_walk);
         case (state_next)
            A_GREEN:  begin light_a <= L_GREEN;  light_b <= L_RED;    walk <= 1'b0; end
            A_YELLOW: begin light_a <= L_YELLOW; light_b <= L_RED;    walk <= 1'b0; end
            B_GREEN:  begin light_a <= L_RED;    light_b <= L_GREEN;  walk <= 1'b0; end
            B_YELLOW: begin light_a <= L_RED;    light_b <= L_YELLOW; walk <= 1'b0; end
            PED_WALK: begin light_a <= L_RED;    light_b <= L_RED;    walk <= 1'b1; end
            FLASH:    begin
                         light_a <= flash_phase_next ? L_OFF : L_YELLOW;
                         light_b <= flash_phase_next ? L_OFF : L_RED;
                         walk    <= 1'b0;
                      end
            default:  begin light_a <= L_RED;    light_b <= L_RED;    walk <= 1'b0; end
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl.
// Expected lamp/pending vectors {light_a, light_b, walk, ped_pending} are
// queued as each cycle's stimulus is driven and compared after the edge.
module tb_traffic_light_ctrl;

   localparam logic [1:0] R = 2'd0;
   localparam logic [1:0] G = 2'd1;
   localparam logic [1:0] Y = 2'd2;
   localparam logic [1:0] O = 2'd3;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0, reset_n3 = 1'b0;
   logic       ped_req = 1'b0, flash_en = 1'b0;
   logic       ped_req3 = 1'b0, flash_en3 = 1'b0;
   logic [1:0] light_a, light_b, light_a3, light_b3;
   logic       walk, ped_pending, walk3, ped_pending3;

   logic [5:0] exp_q[$];
   int         n_vec  = 0;
   int         n_miss = 0;

   always #5 clock = ~clock;

   traffic_light_ctrl #(
      .PRESCALE(1), .CNT_W(8), .GREEN_TICKS(4), .MIN_GREEN_TICKS(2),
      .YELLOW_TICKS(2), .ALL_RED_TICKS(1), .WALK_TICKS(3)
   ) dut (
      .clock(clock), .reset_n(reset_n), .ped_req(ped_req), .flash_en(flash_en),
      .light_a(light_a), .light_b(light_b), .walk(walk), .ped_pending(ped_pending)
   );

   traffic_light_ctrl #(
      .PRESCALE(3), .CNT_W(8), .GREEN_TICKS(4), .MIN_GREEN_TICKS(2),
      .YELLOW_TICKS(2), .ALL_RED_TICKS(1), .WALK_TICKS(3)
   ) dut3 (
      .clock(clock), .reset_n(reset_n3), .ped_req(ped_req3), .flash_en(flash_en3),
      .light_a(light_a3), .light_b(light_b3), .walk(walk3), .ped_pending(ped_pending3)
   );

   task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got la=%0d lb=%0d walk=%0b pend=%0b, want la=%0d lb=%0d walk=%0b pend=%0b",
                  tag, got[5:4], got[3:2], got[1], got[0], exp[5:4], exp[3:2], exp[1], exp[0]);
      end else begin
         $display("ok   %s: la=%0d lb=%0d walk=%0b pend=%0b", tag, got[5:4], got[3:2], got[1], got[0]);
      end
   endtask

   // Run n cycles with the given inputs, expecting the given outputs after each edge.
   task automatic phase(input string tag, input logic [1:0] la, input logic [1:0] lb,
                        input logic w, input logic pp, input int n,
                        input logic pr, input logic fl, input bit sel);
      logic [5:0] got;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({la, lb, w, pp});
         if (sel) ped_req3 = pr;
         else begin
            ped_req  = pr;
            flash_en = fl;
         end
         @(posedge clock);
         #1;
         ped_req  = 1'b0;
         flash_en = 1'b0;
         ped_req3 = 1'b0;
         got = sel ? {light_a3, light_b3, walk3, ped_pending3}
                   : {light_a, light_b, walk, ped_pending};
         check_vec(tag, got, exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check_vec("reset", {light_a, light_b, walk, ped_pending}, {R, R, 1'b0, 1'b0});
      reset_n = 1'b1;
      check_vec("release", {light_a, light_b, walk, ped_pending}, {R, R, 1'b0, 1'b0});

      // Normal two-road cycle, twice round.
      for (int k = 0; k < 2; k++) begin
         phase("a_green",  G, R, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
         phase("a_yellow", Y, R, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
         phase("red_a",    R, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
         phase("b_green",  R, G, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
         phase("b_yellow", R, Y, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
         phase("red_b",    R, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      end

      // Pedestrian request early in A green, then again during the walk.
      phase("ped_a_green", G, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("ped_latch",   G, R, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      phase("ped_a_yel",   Y, R, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      phase("ped_red_a",   R, R, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      phase("walk1_entry", R, R, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("walk1_req",   R, R, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      phase("walk1_end",   R, R, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      phase("short_b_grn", R, G, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      phase("b_yel_pend",  R, Y, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      phase("red_b_pend",  R, R, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      phase("walk2",       R, R, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);

      // Fail-safe flash requested in the first cycle of B green.
      phase("a_green2",    G, R, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
      phase("a_yellow2",   Y, R, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
      phase("red_a2",      R, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("b_green_fl",  R, G, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("b_green_fl",  R, G, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
      phase("b_yel_fl",    R, Y, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
      phase("red_b_fl",    R, R, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         phase("flash_on",  Y, R, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
         phase("flash_off", O, O, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
      end
      phase("flash_exit",  R, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("a_green3",    G, R, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of A yellow with a request pending.
      phase("a_yel_rst",   Y, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("a_yel_req",   Y, R, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      check_vec("async_rst", {light_a, light_b, walk, ped_pending}, {R, R, 1'b0, 1'b0});
      @(posedge clock);
      #1;
      check_vec("rst_held", {light_a, light_b, walk, ped_pending}, {R, R, 1'b0, 1'b0});
      reset_n = 1'b1;
      phase("rst_a_green", G, R, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
      phase("rst_a_yel",   Y, R, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
      phase("rst_red_a",   R, R, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      phase("rst_b_green", R, G, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);

      // Prescaled instance: three clocks per tick.
      reset_n3 = 1'b1;
      check_vec("ps3_release", {light_a3, light_b3, walk3, ped_pending3}, {R, R, 1'b0, 1'b0});
      phase("ps3_red",      R, R, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1);
      phase("ps3_a_green",  G, R, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b1);
      phase("ps3_a_yel",    Y, R, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b1);
      phase("ps3_red_a",    R, R, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b1);
      phase("ps3_b_green",  R, G, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b1);
      phase("ps3_b_yel",    R, Y, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b1);
      phase("ps3_red_b",    R, R, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b1);
      phase("ps3_a_grn2",   G, R, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1);
      phase("ps3_req",      G, R, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b1);
      phase("ps3_a_short",  G, R, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1);
      phase("ps3_a_yel2",   Y, R, 1'b0, 1'b1,  6, 1'b0, 1'b0, 1'b1);
      phase("ps3_red_a2",   R, R, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b1);
      phase("ps3_walk",     R, R, 1'b1, 1'b0,  9, 1'b0, 1'b0, 1'b1);
      phase("ps3_b_grn2",   R, G, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-road intersection controller. It is the parametrised successor of the single-road three-phase light sequencer. Each road has a light, phases are timed in prescaled ticks, and the block adds all-red clearance, a latched pedestrian request with walk phase, and a flashing fail-safe mode. It sits between a free-running system clock and the lamp drivers and pedestrian push-button sync logic.

Parameters:
PRESCALE, 10, clock cycles per tick (>=1)
CNT_W, 8, width of the phase counter; every *_TICKS value must be < 2**CNT_W
GREEN_TICKS, 20, full green duration per road (>=1)
MIN_GREEN_TICKS, 5, minimum green before early termination (1..GREEN_TICKS)
YELLOW_TICKS, 4, yellow duration (>=1)
ALL_RED_TICKS, 2, clearance duration with both roads red (>=1)
WALK_TICKS, 8, pedestrian walk duration (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
ped_req  input  1  pedestrian request, synchronous, pulse or level
flash_en  input  1  fail-safe flash request, synchronous level
light_a  output  2  road A light: 0 RED, 1 GREEN, 2 YELLOW, 3 OFF
light_b  output  2  road B light, same encoding
walk  output  1  pedestrian walk lamp
ped_pending  output  1  request latched, not yet served

Behaviour:
- Reset (async assert, sync release):
  - state=ALL_RED_B, light_a=light_b=RED, walk=0, ped_pending=0.
  - Prescaler=0, phase_cnt=0, next_is_b=0, flash_phase=0.
  - Reset asserted mid-operation forces these values immediately.
- Tick:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - tick=1 on the cycle where prescaler==PRESCALE-1. With PRESCALE=1, tick is 1 every cycle.
- Timing:
  - State and phase_cnt advance only on tick.
  - phase_cnt increments each tick and clears on every state change.
  - A state with duration D is left on the tick where phase_cnt==D-1, so it lasts exactly D ticks.
- Outputs are registered. They change on the same edge as the state register and decode the new state.
- States and lights (light_a/light_b/walk):
  - A_GREEN: G/R/0
  - A_YELLOW: Y/R/0
  - ALL_RED_A: R/R/0
  - B_GREEN: R/G/0
  - B_YELLOW: R/Y/0
  - ALL_RED_B: R/R/0
  - PED_WALK: R/R/1
  - FLASH: see below
- Transitions:
  - A_GREEN -> A_YELLOW -> ALL_RED_A. At the end of ALL_RED_A, next_is_b is set to 1.
  - B_GREEN -> B_YELLOW -> ALL_RED_B. At the end of ALL_RED_B, next_is_b is set to 0.
  - At the end of either ALL_RED state, priority is: flash_en -> FLASH; else ped_pending -> PED_WALK; else the green selected by next_is_b.
  - PED_WALK lasts WALK_TICKS, then goes to the green selected by next_is_b.
- Early green termination: on a tick in a green state, leave to yellow if either holds:
  - phase_cnt==GREEN_TICKS-1, or
  - (ped_pending or flash_en) and phase_cnt>=MIN_GREEN_TICKS-1.
- Yellow and all-red phases always run to full length. flash_en never skips them.
- ped_pending:
  - Set on any clock with ped_req=1, tick or not.
  - Cleared on the edge entering PED_WALK.
  - Set wins over clear when both occur on the same edge.
  - Early termination uses the registered ped_pending, so a ped_req coincident with a tick takes effect from the next tick.
- FLASH:
  - flash_phase toggles each tick.
  - flash_phase=0: light_a=YELLOW, light_b=RED. flash_phase=1: both OFF. walk=0.
  - FLASH is entered with flash_phase=0.
  - On a tick with flash_en=0, go to ALL_RED_B (full duration), then A_GREEN or PED_WALK per the usual priority.
  - ped_req stays latched during FLASH.
- Invariants:
  - Never both lights non-RED at once, except in FLASH, where B is RED or OFF and A is YELLOW or OFF.
  - walk=1 only while both lights are RED.

Test Plan:
Bench configuration unless noted: PRESCALE=1, GREEN=4, MIN_GREEN=2, YELLOW=2, ALL_RED=1, WALK=3.
1. Reset, then release -> RED/RED for 1 cycle; then A G×4, A Y×2, RR×1, B G×4, B Y×2, RR×1. Period is 14 cycles, repeating, walk=0 throughout.
2. ped_req pulse in the first cycle of A_GREEN -> ped_pending=1 next cycle; A green lasts 2 cycles; Y×2, RR×1; walk=1 for 3 cycles with ped_pending cleared at walk entry; then B_GREEN.
3. ped_req pulse during PED_WALK -> ped_pending stays 1 after walk ends; B green shortened to 2; second PED_WALK after ALL_RED_B; then A_GREEN.
4. flash_en=1 mid B_GREEN -> B green ends at MIN_GREEN; B Y×2, RR×1; then light_a alternates 2,3,2,3 with light_b 0,3,0,3. Drop flash_en -> RR×1, then A_GREEN.
5. reset_n low mid A_YELLOW (between clock edges) -> light_a=light_b=RED and walk=0 immediately, ped_pending=0; normal sequence restarts after release.
6. PRESCALE=3 -> every phase spans 3× as many clocks (A green = 12 cycles). A ped_req in a non-tick cycle is still latched.
